// File: rtl/LA_trig_pkg.sv
// Shared types and constants for the logic analyzer protocol triggers.
package LA_trig_pkg;

  typedef enum logic {IDLE, RX} spi_state_t;

  localparam int SPI_CNT_W    = 5;
  localparam int SPI_MAX_BITS = 16;

  // Bit counter parks here so over-long frames can never look like 8 or 16.
  localparam logic [SPI_CNT_W-1:0] SPI_CNT_SAT = SPI_CNT_W'(SPI_MAX_BITS + 1);

  // Masked compare of a received word; 8-bit mode looks at the low byte only.
  function automatic logic spi_word_hit(input logic [15:0] shft,
                                        input logic [15:0] match,
                                        input logic [15:0] mask,
                                        input logic        len8);
    logic [15:0] diff;
    diff = (shft ^ match) & ~mask;
    return len8 ? (diff[7:0] == 8'h00) : (diff == 16'h0000);
  endfunction

endpackage

// File: rtl/spi_prot_trig_if.sv
// SPI wires as seen on analyzer channels CH1-CH3.
interface spi_prot_trig_if;
  logic SS_n;
  logic SCLK;
  logic MOSI;

  modport master (output SS_n, output SCLK, output MOSI);
  modport slave  (input  SS_n, input  SCLK, input  MOSI);
endinterface

// File: rtl/sync_edge_det.sv
// Multi-flop synchronizer followed by one edge-detect flop.
// o_q is the edge-detect flop, so it lags the pin by STAGES+1 clocks.
module sync_edge_det #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q,
  output logic o_rise,
  output logic o_fall
);

  logic [STAGES-1:0] r_sync;
  logic              r_dly;

  // Shift the asynchronous pin through the synchronizer and edge flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= {STAGES{RST_VAL}};
      r_dly  <= RST_VAL;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
      r_dly  <= r_sync[STAGES-1];
    end
  end

  assign o_q    = r_dly;
  assign o_rise =  r_sync[STAGES-1] & ~r_dly;
  assign o_fall = ~r_sync[STAGES-1] &  r_dly;

endmodule

// File: rtl/spi_prot_trig.sv
// Passive SPI receive snooper: deframes 8/16-bit MSB-first words and pulses
// SPItrig when a complete frame matches match/mask while armed.
//
// state | meaning
// IDLE  | SS_n high (or frame just closed); SCLK edges ignored
// RX    | SS_n low; shifting MOSI on the selected SCLK edge
module spi_prot_trig
  import LA_trig_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  spi_prot_trig_if.slave       spi,
  input  logic                 pos_edge,
  input  logic                 len8,
  input  logic                 armed,
  input  logic [15:0]          match,
  input  logic [15:0]          mask,
  output logic                 SPItrig,
  output logic                 busy
);

  logic w_ss_rise, w_ss_fall, w_ss_q_unused;
  logic w_sclk_rise, w_sclk_fall, w_sclk_q_unused;
  logic w_mosi_q, w_mosi_rise_unused, w_mosi_fall_unused;
  logic w_sclk_edge, w_cnt_ok, w_hit;

  spi_state_t                r_state;
  logic [15:0]               r_shft;
  logic [SPI_CNT_W-1:0]      r_cnt;
  logic                      r_trig;
  logic                      r_busy;

  sync_edge_det #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ss (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_d    (spi.SS_n),
    .o_q    (w_ss_q_unused),
    .o_rise (w_ss_rise),
    .o_fall (w_ss_fall)
  );

  sync_edge_det #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_d    (spi.SCLK),
    .o_q    (w_sclk_q_unused),
    .o_rise (w_sclk_rise),
    .o_fall (w_sclk_fall)
  );

  // MOSI taken from the edge-detect flop: aligned with the pre-edge SCLK level.
  sync_edge_det #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_d    (spi.MOSI),
    .o_q    (w_mosi_q),
    .o_rise (w_mosi_rise_unused),
    .o_fall (w_mosi_fall_unused)
  );

  assign w_sclk_edge = pos_edge ? w_sclk_rise : w_sclk_fall;
  assign w_cnt_ok    = len8 ? (r_cnt == SPI_CNT_W'(8))
                            : (r_cnt == SPI_CNT_W'(SPI_MAX_BITS));
  assign w_hit       = spi_word_hit(r_shft, match, mask, len8);

  // Frame FSM with shifter, saturating bit counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_shft  <= '0;
      r_cnt   <= '0;
      r_trig  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_trig <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_ss_fall) begin
            r_state <= RX;
            r_shft  <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end
        end
        RX: begin
          if (w_ss_rise) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_trig  <= w_cnt_ok & w_hit & armed;
          end else if (w_sclk_edge) begin
            r_shft <= {r_shft[14:0], w_mosi_q};
            if (r_cnt != SPI_CNT_SAT)
              r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign SPItrig = r_trig;
  assign busy    = r_busy;

endmodule

// File: tb/tb_spi_prot_trig.sv
// Self-checking bench for spi_prot_trig: SPI master stimulus at clk/32,
// expected trigger outcome queued per frame and compared after SS_n rises.
module tb_spi_prot_trig;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pos_edge, len8, armed;
  logic [15:0] match, mask;
  logic        SPItrig, busy;

  int n_tests = 0;
  int n_fail  = 0;
  int n_pulse = 0;
  int n_exp_pulse = 0;
  int exp_q[$];

  spi_prot_trig_if bus ();

  spi_prot_trig dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .spi      (bus),
    .pos_edge (pos_edge),
    .len8     (len8),
    .armed    (armed),
    .match    (match),
    .mask     (mask),
    .SPItrig  (SPItrig),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Running count of every trigger pulse, to catch pulses outside frame windows.
  always @(negedge clk) begin
    if (rst_n && SPItrig === 1'b1) n_pulse++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cfg(input logic pe, input logic l8, input logic arm,
                     input logic [15:0] m, input logic [15:0] k);
    pos_edge = pe; len8 = l8; armed = arm; match = m; mask = k;
  endtask

  // One SPI frame, CPOL=0, MSB first. Rise mode: data changes 4 clk after the
  // rising edge; neg mode: data changes 4 clk after the falling edge.
  task automatic send(input logic [16:0] data, input int nbits, input bit neg_mode,
                      input int exp_trig, input string tag);
    int   seen;
    int   idx;
    logic nxt;
    exp_q.push_back(exp_trig);
    if (exp_trig != 0) n_exp_pulse++;
    bus.SS_n = 1'b0;
    bus.MOSI = data[nbits-1];
    clks(8);
    chk({tag, "_busy_hi"}, {31'b0, busy}, 32'd1);
    clks(8);
    for (int i = nbits - 1; i >= 0; i--) begin
      idx = (i > 0) ? i - 1 : 0;
      nxt = (i > 0) ? data[idx] : 1'b0;
      bus.SCLK = 1'b1;
      if (!neg_mode) begin
        clks(4);  bus.MOSI = nxt;
        clks(12); bus.SCLK = 1'b0;
        clks(16);
      end else begin
        clks(16); bus.SCLK = 1'b0;
        clks(4);  bus.MOSI = nxt;
        clks(12);
      end
    end
    bus.SS_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      clks(1);
      if (SPItrig === 1'b1) seen++;
    end
    chk({tag, "_busy_lo"}, {31'b0, busy}, 32'd0);
    chk({tag, "_trig"}, seen, exp_q.pop_front());
    clks(4);
  endtask

  initial begin
    bus.SS_n = 1'b1; bus.SCLK = 1'b0; bus.MOSI = 1'b0;
    cfg(1'b1, 1'b0, 1'b1, 16'hBEEF, 16'h0000);
    clks(3);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_trig", {31'b0, SPItrig}, 32'd0);
    rst_n = 1'b1;
    clks(5);
    chk("idle_busy", {31'b0, busy}, 32'd0);
    chk("idle_trig", {31'b0, SPItrig}, 32'd0);

    send(17'h0BEEF, 16, 1'b0, 1, "m16");

    cfg(1'b1, 1'b1, 1'b1, 16'h00A0, 16'h000F);
    send(17'h000A5, 8, 1'b0, 1, "m8_mask");
    cfg(1'b1, 1'b1, 1'b1, 16'h00B0, 16'h000F);
    send(17'h000A5, 8, 1'b0, 0, "m8_nomatch");

    cfg(1'b0, 1'b0, 1'b1, 16'hBEEF, 16'h0000);
    send(17'h0BEEF, 16, 1'b0, 0, "wrong_edge");
    send(17'h0BEEF, 16, 1'b1, 1, "neg_edge");

    cfg(1'b1, 1'b1, 1'b1, 16'h00EF, 16'h0000);
    send(17'h0BEEF, 16, 1'b0, 0, "len_mismatch");

    cfg(1'b1, 1'b0, 1'b0, 16'hBEEF, 16'h0000);
    send(17'h0BEEF, 16, 1'b0, 0, "disarmed");
    armed = 1'b1;
    send(17'h0BEEF, 16, 1'b0, 1, "rearmed");

    cfg(1'b1, 1'b0, 1'b1, 16'h0000, 16'hFFFF);
    send(17'h01234, 16, 1'b0, 1, "mask_all16");
    send(17'h1FFFF, 17, 1'b0, 0, "long17");
    cfg(1'b1, 1'b1, 1'b1, 16'h0000, 16'hFFFF);
    send(17'h0005A, 8, 1'b0, 1, "mask_all8");
    send(17'h0005A, 7, 1'b0, 0, "short8");
    cfg(1'b1, 1'b0, 1'b1, 16'hBEEF, 16'h0000);
    send(17'h00EEF, 12, 1'b0, 0, "short16");

    // Reset in the middle of a frame after 6 rising SCLK edges.
    bus.SS_n = 1'b0; bus.MOSI = 1'b1;
    clks(16);
    for (int i = 0; i < 6; i++) begin
      bus.SCLK = 1'b1; clks(16);
      bus.SCLK = 1'b0; clks(16);
    end
    chk("midrst_busy_pre", {31'b0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", {31'b0, busy}, 32'd0);
    chk("midrst_trig", {31'b0, SPItrig}, 32'd0);
    clks(2);
    bus.SS_n = 1'b1; bus.SCLK = 1'b0; bus.MOSI = 1'b0;
    clks(4);
    rst_n = 1'b1;
    clks(6);
    chk("postrst_busy", {31'b0, busy}, 32'd0);
    send(17'h0BEEF, 16, 1'b0, 1, "after_rst");

    clks(10);
    chk("total_pulses", n_pulse, n_exp_pulse);
    chk("queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
